// File: rtl/bounded_step_counter_bank.sv
// Bank of NCH independent bounded step counters. Each channel advances a position
// register by STEP per request while it is within LIMIT, counting the advances taken.
module bounded_step_counter_bank #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int START = 1,
    parameter int LIMIT = 200,
    parameter int STEP  = 1,
    parameter int WRAP  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             sel,
    input  logic [NCH-1:0]             clr,
    output logic [NCH*WIDTH-1:0]       i,
    output logic [NCH*WIDTH-1:0]       sn,
    output logic [NCH-1:0]             done,
    output logic [NCH-1:0]             wrap_pulse,
    output logic [$clog2(NCH+1)-1:0]   active_cnt,
    output logic                       all_done
);

    localparam int     CW      = $clog2(NCH + 1);
    localparam longint MAX_VAL = (longint'(1) << WIDTH) - 1;
    localparam bit     WRAP_EN = (WRAP != 0);

    // The advance from LIMIT must still fit in WIDTH bits, so a held channel never overflows.
    if (longint'(LIMIT) + longint'(STEP) > MAX_VAL) begin : g_chk_range
        $fatal(1, "LIMIT + STEP must not exceed 2^WIDTH - 1");
    end
    if (START > LIMIT) begin : g_chk_start
        $fatal(1, "START must not exceed LIMIT");
    end
    if (STEP < 1) begin : g_chk_step
        $fatal(1, "STEP must be at least 1");
    end
    if (NCH < 1) begin : g_chk_nch
        $fatal(1, "NCH must be at least 1");
    end

    logic [WIDTH-1:0] pos_q [NCH];
    logic [WIDTH-1:0] cnt_q [NCH];
    logic [NCH-1:0]   wp_q;

    // NOTE: state registers use non-blocking assignments so every channel samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                pos_q[k] <= WIDTH'(START);
                cnt_q[k] <= '0;
            end
            wp_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                wp_q[k] <= 1'b0;
                if (clr[k]) begin
                    pos_q[k] <= WIDTH'(START);
                    cnt_q[k] <= '0;
                end else if (sel[k]) begin
                    if (!done[k]) begin
                        pos_q[k] <= pos_q[k] + WIDTH'(STEP);
                        cnt_q[k] <= cnt_q[k] + WIDTH'(1);
                    end else if (WRAP_EN) begin
                        pos_q[k] <= WIDTH'(START);
                        cnt_q[k] <= '0;
                        wp_q[k]  <= 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        logic [CW-1:0] cnt;
        i          = '0;
        sn         = '0;
        done       = '0;
        cnt        = '0;
        for (int k = 0; k < NCH; k++) begin
            i[k*WIDTH +: WIDTH]  = pos_q[k];
            sn[k*WIDTH +: WIDTH] = cnt_q[k];
            done[k]              = (pos_q[k] > WIDTH'(LIMIT));
            cnt                  = cnt + CW'(!done[k]);
        end
        active_cnt = cnt;
        all_done   = &done;
        wrap_pulse = wp_q;
    end

endmodule

// File: tb/tb_bounded_step_counter_bank.sv
// Self-checking bench: three bank instances (hold, wrap, step-3) share stimulus and are
// compared against a step-count model in which position is derived as START + STEP*count.
module tb_bounded_step_counter_bank;

    localparam int N  = 4;
    localparam int ND = 3;
    localparam int C_STEP [ND] = '{1, 1, 3};
    localparam int C_WRAP [ND] = '{0, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [3:0] sel = '0;
    logic [3:0] clr = '0;

    logic [31:0] d_i    [ND];
    logic [31:0] d_sn   [ND];
    logic [3:0]  d_done [ND];
    logic [3:0]  d_wp   [ND];
    logic [2:0]  d_ac   [ND];
    logic        d_ad   [ND];

    int m_sn [ND][N];
    bit m_wp [ND][N];
    int vecs = 0;
    int errs = 0;

    bounded_step_counter_bank #(.WIDTH(8), .NCH(4), .START(1), .LIMIT(200), .STEP(1), .WRAP(0)) dut_hold (
        .clk(clk), .rst(rst), .sel(sel), .clr(clr), .i(d_i[0]), .sn(d_sn[0]), .done(d_done[0]),
        .wrap_pulse(d_wp[0]), .active_cnt(d_ac[0]), .all_done(d_ad[0]));
    bounded_step_counter_bank #(.WIDTH(8), .NCH(4), .START(1), .LIMIT(200), .STEP(1), .WRAP(1)) dut_wrap (
        .clk(clk), .rst(rst), .sel(sel), .clr(clr), .i(d_i[1]), .sn(d_sn[1]), .done(d_done[1]),
        .wrap_pulse(d_wp[1]), .active_cnt(d_ac[1]), .all_done(d_ad[1]));
    bounded_step_counter_bank #(.WIDTH(8), .NCH(4), .START(1), .LIMIT(200), .STEP(3), .WRAP(0)) dut_step3 (
        .clk(clk), .rst(rst), .sel(sel), .clr(clr), .i(d_i[2]), .sn(d_sn[2]), .done(d_done[2]),
        .wrap_pulse(d_wp[2]), .active_cnt(d_ac[2]), .all_done(d_ad[2]));

    function automatic int exp_i(int c, int k);
        return 1 + C_STEP[c] * m_sn[c][k];
    endfunction

    function automatic logic [3:0] exp_done(int c);
        logic [3:0] r;
        for (int k = 0; k < N; k++) r[k] = (exp_i(c, k) > 200);
        return r;
    endfunction

    function automatic logic [3:0] exp_wp(int c);
        logic [3:0] r;
        for (int k = 0; k < N; k++) r[k] = m_wp[c][k];
        return r;
    endfunction

    function automatic int exp_ac(int c);
        int n = 0;
        for (int k = 0; k < N; k++) if (exp_i(c, k) <= 200) n++;
        return n;
    endfunction

    // Advance the model with the current inputs, then let the DUTs take one edge.
    task automatic step();
        int nsn [ND][N];
        bit nwp [ND][N];
        for (int c = 0; c < ND; c++) begin
            for (int k = 0; k < N; k++) begin
                nwp[c][k] = 1'b0;
                nsn[c][k] = m_sn[c][k];
                if (rst || clr[k]) nsn[c][k] = 0;
                else if (sel[k] && exp_i(c, k) <= 200) nsn[c][k] = m_sn[c][k] + 1;
                else if (sel[k] && C_WRAP[c] != 0) begin
                    nsn[c][k] = 0;
                    nwp[c][k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_sn = nsn;
        m_wp = nwp;
    endtask

    task automatic do_reset();
        rst = 1'b1; sel = '0; clr = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 4'hF; clr = 4'h0;
        step();
        rst = 1'b0;
        for (int c = 0; c < ND; c++) begin
            vecs++;
            if (d_i[c] !== 32'h01010101) begin errs++; $display("FAIL reset_i dut%0d got %h exp 01010101", c, d_i[c]); end
            vecs++;
            if (d_sn[c] !== 32'h0) begin errs++; $display("FAIL reset_sn dut%0d got %h exp 0", c, d_sn[c]); end
            vecs++;
            if (d_done[c] !== 4'h0 || d_wp[c] !== 4'h0) begin
                errs++; $display("FAIL reset_flags dut%0d done %b wp %b exp 0000 0000", c, d_done[c], d_wp[c]);
            end
            vecs++;
            if (d_ac[c] !== 3'd4 || d_ad[c] !== 1'b0) begin
                errs++; $display("FAIL reset_summary dut%0d active %0d all_done %b exp 4 0", c, d_ac[c], d_ad[c]);
            end
        end
    endtask

    task automatic test_single_channel();
        do_reset();
        sel = 4'b0001;
        for (int n = 1; n <= 210; n++) begin
            step();
            vecs++;
            if (d_done[0] !== ((n >= 200) ? 4'b0001 : 4'b0000)) begin
                errs++; $display("FAIL single_done cycle %0d got %b exp %b", n, d_done[0], (n >= 200) ? 4'b0001 : 4'b0000);
            end
        end
        vecs++;
        if (d_i[0][7:0] !== 8'd201 || d_sn[0][7:0] !== 8'd200) begin
            errs++; $display("FAIL single_final got i %0d sn %0d exp 201 200", d_i[0][7:0], d_sn[0][7:0]);
        end
        vecs++;
        if (d_ac[0] !== 3'd3 || d_ad[0] !== 1'b0) begin
            errs++; $display("FAIL single_summary got active %0d all_done %b exp 3 0", d_ac[0], d_ad[0]);
        end
        vecs++;
        if (d_i[0][31:8] !== 24'h010101 || d_sn[0][31:8] !== 24'h0) begin
            errs++; $display("FAIL single_idle got i %h sn %h exp 010101 000000", d_i[0][31:8], d_sn[0][31:8]);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sel = 4'($urandom_range(0, 15));
            sel[2] = n[0];
            step();
            for (int k = 0; k < N; k++) begin
                vecs++;
                if (int'(d_i[0][k*8 +: 8]) != int'(d_sn[0][k*8 +: 8]) + 1 || d_i[0][k*8 +: 8] > 8'd201) begin
                    errs++; $display("FAIL toggle_invariant ch%0d got i %0d sn %0d exp i = sn + 1 <= 201",
                                     k, d_i[0][k*8 +: 8], d_sn[0][k*8 +: 8]);
                end
            end
            for (int c = 0; c < ND; c++) begin
                for (int k = 0; k < N; k++) begin
                    vecs++;
                    if (int'(d_i[c][k*8 +: 8]) != exp_i(c, k) || int'(d_sn[c][k*8 +: 8]) != m_sn[c][k]) begin
                        errs++; $display("FAIL toggle_model dut%0d ch%0d got i %0d sn %0d exp %0d %0d",
                                         c, k, d_i[c][k*8 +: 8], d_sn[c][k*8 +: 8], exp_i(c, k), m_sn[c][k]);
                    end
                end
            end
        end
        vecs++;
        if (d_i[0][23:16] !== 8'd201 || d_sn[0][23:16] !== 8'd200) begin
            errs++; $display("FAIL toggle_final got i2 %0d sn2 %0d exp 201 200", d_i[0][23:16], d_sn[0][23:16]);
        end
    endtask

    task automatic test_clr_priority();
        do_reset();
        sel = 4'hF;
        repeat (10) step();
        sel = 4'b0010;
        repeat (39) step();
        vecs++;
        if (d_i[0][15:8] !== 8'd50 || d_sn[0][15:8] !== 8'd49) begin
            errs++; $display("FAIL clr_setup got i1 %0d sn1 %0d exp 50 49", d_i[0][15:8], d_sn[0][15:8]);
        end
        clr = 4'b0010;
        step();
        clr = 4'b0000;
        sel = 4'b0000;
        vecs++;
        if (d_i[0][15:8] !== 8'd1 || d_sn[0][15:8] !== 8'd0) begin
            errs++; $display("FAIL clr_wins got i1 %0d sn1 %0d exp 1 0", d_i[0][15:8], d_sn[0][15:8]);
        end
        vecs++;
        if (d_i[0] !== 32'h0B0B010B || d_sn[0] !== 32'h0A0A000A) begin
            errs++; $display("FAIL clr_others got i %h sn %h exp 0b0b010b 0a0a000a", d_i[0], d_sn[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        sel = 4'b0001;
        repeat (200) step();
        vecs++;
        if (d_i[1][7:0] !== 8'd201 || d_sn[1][7:0] !== 8'd200 || d_done[1][0] !== 1'b1) begin
            errs++; $display("FAIL wrap_reach got i0 %0d sn0 %0d done %b exp 201 200 1", d_i[1][7:0], d_sn[1][7:0], d_done[1][0]);
        end
        sel = 4'b0000;
        repeat (3) step();
        vecs++;
        if (d_i[1][7:0] !== 8'd201 || d_wp[1] !== 4'b0000) begin
            errs++; $display("FAIL wrap_hold got i0 %0d wp %b exp 201 0000", d_i[1][7:0], d_wp[1]);
        end
        sel = 4'b0001;
        step();
        sel = 4'b0000;
        vecs++;
        if (d_i[1][7:0] !== 8'd1 || d_sn[1][7:0] !== 8'd0 || d_wp[1] !== 4'b0001) begin
            errs++; $display("FAIL wrap_reload got i0 %0d sn0 %0d wp %b exp 1 0 0001", d_i[1][7:0], d_sn[1][7:0], d_wp[1]);
        end
        vecs++;
        if (d_i[0][7:0] !== 8'd201 || d_sn[0][7:0] !== 8'd200 || d_wp[0] !== 4'b0000) begin
            errs++; $display("FAIL nowrap_hold got i0 %0d sn0 %0d wp %b exp 201 200 0000", d_i[0][7:0], d_sn[0][7:0], d_wp[0]);
        end
        step();
        vecs++;
        if (d_wp[1] !== 4'b0000 || d_i[1][7:0] !== 8'd1) begin
            errs++; $display("FAIL wrap_pulse_len got wp %b i0 %0d exp 0000 1", d_wp[1], d_i[1][7:0]);
        end
    endtask

    task automatic test_step3();
        do_reset();
        sel = 4'b1000;
        for (int n = 1; n <= 70; n++) begin
            step();
            vecs++;
            if (int'(d_i[2][31:24]) != ((n <= 67) ? 1 + 3 * n : 202) ||
                int'(d_sn[2][31:24]) != ((n <= 67) ? n : 67) || d_done[2][3] !== (n >= 67)) begin
                errs++; $display("FAIL step3 cycle %0d got i3 %0d sn3 %0d done %b exp %0d %0d %0d", n,
                                 d_i[2][31:24], d_sn[2][31:24], d_done[2][3], (n <= 67) ? 1 + 3 * n : 202,
                                 (n <= 67) ? n : 67, n >= 67);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sel = 4'hF;
        repeat (205) step();
        vecs++;
        if (d_ad[0] !== 1'b1 || d_ac[0] !== 3'd0 || d_done[0] !== 4'hF) begin
            errs++; $display("FAIL all_done_hold got all %b active %0d done %b exp 1 0 1111", d_ad[0], d_ac[0], d_done[0]);
        end
        vecs++;
        if (d_ad[2] !== 1'b1 || d_ac[2] !== 3'd0 || d_i[2] !== 32'hCACACACA) begin
            errs++; $display("FAIL all_done_step3 got all %b active %0d i %h exp 1 0 cacacaca", d_ad[2], d_ac[2], d_i[2]);
        end
        rst = 1'b1; sel = 4'hF; clr = 4'h0;
        step();
        rst = 1'b0; sel = 4'h0;
        for (int c = 0; c < ND; c++) begin
            vecs++;
            if (d_i[c] !== 32'h01010101 || d_sn[c] !== 32'h0 || d_ad[c] !== 1'b0 || d_ac[c] !== 3'd4) begin
                errs++; $display("FAIL rst_override dut%0d got i %h sn %h all %b active %0d exp 01010101 0 0 4",
                                 c, d_i[c], d_sn[c], d_ad[c], d_ac[c]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            sel = 4'($urandom_range(0, 15));
            clr = '0;
            for (int k = 0; k < N; k++) clr[k] = ($urandom_range(0, 15) == 0);
            step();
            for (int c = 0; c < ND; c++) begin
                for (int k = 0; k < N; k++) begin
                    vecs++;
                    if (int'(d_i[c][k*8 +: 8]) != exp_i(c, k) || int'(d_sn[c][k*8 +: 8]) != m_sn[c][k]) begin
                        errs++; $display("FAIL random_pos dut%0d ch%0d got i %0d sn %0d exp %0d %0d",
                                         c, k, d_i[c][k*8 +: 8], d_sn[c][k*8 +: 8], exp_i(c, k), m_sn[c][k]);
                    end
                end
                vecs++;
                if (d_done[c] !== exp_done(c) || d_wp[c] !== exp_wp(c) ||
                    int'(d_ac[c]) != exp_ac(c) || d_ad[c] !== (&exp_done(c))) begin
                    errs++; $display("FAIL random_flags dut%0d got done %b wp %b active %0d all %b exp %b %b %0d %b",
                                     c, d_done[c], d_wp[c], d_ac[c], d_ad[c], exp_done(c), exp_wp(c),
                                     exp_ac(c), &exp_done(c));
                end
            end
        end
        rst = 1'b0; sel = '0; clr = '0;
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_toggle();
        test_clr_priority();
        test_wrap();
        test_step3();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bounded_step_counter_bank.md
Name: bounded_step_counter_bank

Overview:
- Bank of NCH independent bounded step counters. Each channel pairs a position register i (starts at START, advances by STEP while i <= LIMIT) with a step count sn.
- Successor to the single-channel fixed-bound i/sn counter: generalised in width, channel count, start, limit and step.
- Adds a per-channel synchronous clear, an optional wrap/reload mode, done flags and a bank-level activity summary.
- Used as a parametrised loop-bound stimulus/property-mining block in the arithmetic case set.

Parameters:
- WIDTH, 8, bit width of each i and sn register.
- NCH, 4, number of channels.
- START, 1, reset/reload value of i.
- LIMIT, 200, last value of i from which an advance is allowed.
- STEP, 1, increment applied to i per advance (>= 1).
- WRAP, 0, 0 = hold when bound is passed; 1 = reload channel on next sel after bound is passed.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- sel, input, NCH, per-channel advance request.
- clr, input, NCH, per-channel synchronous re-initialise.
- i, output, NCH*WIDTH, channel k position at [k*WIDTH +: WIDTH], registered.
- sn, output, NCH*WIDTH, channel k step count at [k*WIDTH +: WIDTH], registered.
- done, output, NCH, done[k] = (i_k > LIMIT), combinational from registered i.
- wrap_pulse, output, NCH, registered; 1 for exactly one cycle after a reload.
- active_cnt, output, $clog2(NCH+1), number of channels with done = 0, combinational.
- all_done, output, 1, AND of all done bits.

Behaviour:
- Elaboration checks, each a fatal error: LIMIT + STEP <= 2^WIDTH - 1; START <= LIMIT; STEP >= 1; NCH >= 1.
- Reset (rst = 1, evaluated at clk edge):
  - every i = START, every sn = 0, every wrap_pulse = 0.
  - Hence done = 0, active_cnt = NCH, all_done = 0.
- Per-channel priority on each edge, highest first: rst > clr[k] > advance/reload > hold.
- clr[k] = 1: i_k = START, sn_k = 0, wrap_pulse[k] = 0. This holds regardless of sel[k]. Other channels are unaffected.
- Advance, when sel[k] = 1 and i_k <= LIMIT: i_k += STEP and sn_k += 1 in the same cycle. Latency is 1 cycle.
- Past bound (i_k > LIMIT):
  - WRAP = 0: i_k and sn_k hold regardless of sel[k]; no overflow is possible.
  - WRAP = 1 and sel[k] = 1: i_k = START, sn_k = 0, wrap_pulse[k] = 1 next cycle.
  - WRAP = 1 and sel[k] = 0: hold.
- sel[k] = 0 (and no clr/rst): hold. wrap_pulse[k] returns to 0 on any cycle it is not set.
- Invariant, every cycle, every channel: i_k == START + STEP*sn_k. When done[k] = 1, sn_k == floor((LIMIT - START)/STEP) + 1.
  - Defaults: the final state is i = 201, sn = 200, and (i > 200) implies sn == 200.
- done and active_cnt follow register values with zero added latency. active_cnt is a popcount of ~done.
- Reset mid-operation overrides all pending sel/clr. There is no partial update.

Test Plan:
- Defaults. Reset, then sel = 4'b0001 held for 210 cycles -> i0 = 201, sn0 = 200, done = 4'b0001 from cycle 200 onward, active_cnt = 3. Channels 1-3 stay at i = 1, sn = 0.
- sel[2] toggled every cycle for 400 cycles, random sel on the other channels -> i2 = 201, sn2 = 200. Invariant i = sn + 1 checked on all channels every cycle; i never exceeds 201.
- Channel 1 at i = 50, sn = 49; assert clr[1] = 1 and sel[1] = 1 on the same cycle -> next cycle i1 = 1, sn1 = 0, other channels unchanged.
- WRAP = 1. Drive channel 0 to i = 201, then one more sel[0] -> i0 = 1, sn0 = 0, wrap_pulse[0] = 1 for exactly one cycle. With sel[0] = 0 at i = 201, the channel holds.
- STEP = 3, LIMIT = 200. Continuous sel[3] -> sequence 1, 4, ..., 199, 202; final sn3 = 67, done[3] = 1, and 202 holds.
- All four channels done (all_done = 1, active_cnt = 0), then rst asserted together with sel = 4'hF and clr = 4'h0 -> all i = 1, sn = 0, all_done = 0, active_cnt = 4.
